// File: rtl/hybrid_decryption_top.sv
// Hybrid ECC-AES decryption core: bit-serial modular multiply recovers the session key,
// then an iterative AES-128 inverse cipher decrypts one block.
module hybrid_decryption_top #(
  parameter logic [255:0] P_MOD = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] C1,
  input  logic [255:0] C2,
  input  logic [255:0] d,
  input  logic [127:0] Cipher_test,
  input  logic [127:0] Aes_key,
  output logic [127:0] plain_text,
  output logic [127:0] M_out,
  output logic         Done
);

  typedef enum logic [2:0] {IDLE, ECC, KEXP, AES, DONE} state_t;

  localparam logic [2047:0] SBOX_T = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [2047:0] INV_SBOX_T = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_T[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX_T[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd0: return 8'h01;  4'd1: return 8'h02;  4'd2: return 8'h04;
      4'd3: return 8'h08;  4'd4: return 8'h10;  4'd5: return 8'h20;
      4'd6: return 8'h40;  4'd7: return 8'h80;  4'd8: return 8'h1b;
      default: return 8'h36;
    endcase
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4], mb [4], md [4], me [4];
    for (int i = 0; i < 4; i++) begin
      logic [7:0] x2, x4, x8;
      a[i]  = col[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // One inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless final.
  function automatic logic [127:0] inv_round(input logic [127:0] blk, input logic [127:0] rk,
                                             input logic mix);
    logic [127:0] s;
    for (int k = 0; k < 16; k++) begin
      int src;
      src = 4 * (((k / 4) - (k % 4)) & 3) + (k % 4);
      s[127-8*k -: 8] = inv_sbox(blk[127-8*src -: 8]);
    end
    s = s ^ rk;
    if (mix) begin
      for (int c = 0; c < 4; c++) s[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    end
    return s;
  endfunction

  // Inputs are kept below p, so one conditional subtract restores a < p.
  function automatic logic [255:0] mod_red(input logic [256:0] t);
    return (t >= {1'b0, P_MOD}) ? 256'(t - {1'b0, P_MOD}) : t[255:0];
  endfunction

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [255:0]  c1_q, c1_d, d_q, d_d, acc_q, acc_d;
  logic [127:0]  c2_q, c2_d, ct_q, ct_d, key_q, key_d, blk_q, blk_d;
  logic [127:0]  m_q, m_d, pt_q, pt_d;
  logic          done_q, done_d;

  logic [255:0]  acc_dbl, ecc_nxt;
  logic [127:0]  key_f, key_b, rnd_out;
  logic          unused_c2_hi;

  assign unused_c2_hi = ^C2[255:128];

  assign acc_dbl = mod_red({acc_q, 1'b0});
  assign ecc_nxt = d_q[cnt_q] ? mod_red({1'b0, acc_dbl} + {1'b0, c1_q}) : acc_dbl;
  assign key_f   = key_fwd(key_q, rcon(cnt_q[3:0]));
  assign key_b   = key_inv(key_q, rcon(cnt_q[3:0]));
  assign rnd_out = inv_round(blk_q, key_b, cnt_q != 8'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    c1_d    = c1_q;
    c2_d    = c2_q;
    d_d     = d_q;
    ct_d    = ct_q;
    key_d   = key_q;
    blk_d   = blk_q;
    acc_d   = acc_q;
    m_d     = m_q;
    pt_d    = pt_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        c1_d    = (C1 >= P_MOD) ? C1 - P_MOD : C1;
        c2_d    = C2[127:0];
        d_d     = d;
        ct_d    = Cipher_test;
        key_d   = Aes_key;
        acc_d   = '0;
        cnt_d   = 8'd255;
        state_d = ECC;
      end
      ECC: begin
        acc_d = ecc_nxt;
        if (cnt_q == 8'd0) begin
          m_d     = ecc_nxt[127:0] ^ c2_q;
          state_d = KEXP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      KEXP: begin
        key_d = key_f;
        if (cnt_q == 8'd9) begin
          blk_d   = ct_q ^ key_f;
          state_d = AES;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      AES: begin
        key_d = key_b;
        blk_d = rnd_out;
        if (cnt_q == 8'd0) begin
          pt_d    = rnd_out;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
      d_q     <= '0;
      ct_q    <= '0;
      key_q   <= '0;
      blk_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      pt_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      d_q     <= d_d;
      ct_q    <= ct_d;
      key_q   <= key_d;
      blk_q   <= blk_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      pt_q    <= pt_d;
      done_q  <= done_d;
    end
  end

  assign plain_text = pt_q;
  assign M_out      = m_q;
  assign Done       = done_q;

endmodule

// File: tb/tb_hybrid_decryption_top.sv
// Directed-vector bench for hybrid_decryption_top: session-key recovery, AES decryption,
// latency, input isolation and mid-run reset.
module tb_hybrid_decryption_top;

  localparam logic [255:0] P = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

  typedef struct {
    logic [255:0] c1;
    logic [255:0] c2;
    logic [255:0] d;
    logic [127:0] ct;
    logic [127:0] key;
    logic [127:0] exp_m;
    logic [127:0] exp_pt;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] C1, C2, d;
  logic [127:0] Cipher_test, Aes_key;
  logic [127:0] plain_text, M_out;
  logic         Done;

  int n_cmp  = 0;
  int n_fail = 0;

  vec_t vecs[7];

  always #5 clk = ~clk;

  hybrid_decryption_top dut (
    .clk(clk), .rst(rst), .C1(C1), .C2(C2), .d(d),
    .Cipher_test(Cipher_test), .Aes_key(Aes_key),
    .plain_text(plain_text), .M_out(M_out), .Done(Done)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic start_run(input vec_t v);
    rst         = 1'b0;
    C1          = v.c1;
    C2          = v.c2;
    d           = v.d;
    Cipher_test = v.ct;
    Aes_key     = v.key;
    #2;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Counts edges from the first edge with rst=1 and checks latency and results.
  task automatic run_checks(input vec_t v, input string tag);
    logic done_early = 1'b0;
    logic m_early    = 1'b0;
    for (int e = 1; e <= 282; e++) begin
      @(posedge clk);
      #1;
      if (e < 277 && Done !== 1'b0) done_early = 1'b1;
      if (e < 257 && M_out !== 128'h0) m_early = 1'b1;
      if (e == 1) begin
        C1          = {8{$urandom()}};
        C2          = {8{$urandom()}};
        d           = {8{$urandom()}};
        Cipher_test = {4{$urandom()}};
        Aes_key     = {4{$urandom()}};
      end
      if (e == 257) chk({tag, "_m_at257"}, M_out, v.exp_m);
      if (e == 276) chk({tag, "_done_at276"}, 128'(Done), 128'h0);
      if (e == 277) begin
        chk({tag, "_done_at277"}, 128'(Done), 128'h1);
        chk({tag, "_pt"}, plain_text, v.exp_pt);
      end
      if (e == 282) begin
        chk({tag, "_done_hold"}, 128'(Done), 128'h1);
        chk({tag, "_pt_hold"}, plain_text, v.exp_pt);
        chk({tag, "_m_hold"}, M_out, v.exp_m);
      end
    end
    chk({tag, "_done_early"}, 128'(done_early), 128'h0);
    chk({tag, "_m_early"}, 128'(m_early), 128'h0);
  endtask

  initial begin
    vecs[0] = '{c1: 256'd5, c2: 256'h0, d: 256'd1,
                ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, key: 128'h000102030405060708090a0b0c0d0e0f,
                exp_m: 128'h5, exp_pt: 128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{c1: P - 256'd1, c2: 256'h0, d: 256'd2,
                ct: 128'h3925841d02dc09fbdc118597196a0b32, key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                exp_m: 128'h00000000FFFFFFFFFFFFFFFFFFFFFFFD, exp_pt: 128'h3243f6a8885a308d313198a2e0370734};
    vecs[2] = '{c1: 256'hdeadbeef, c2: 256'h0f1571c947d9e8590cb7add6af7f6798, d: 256'h0,
                ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, key: 128'h0,
                exp_m: 128'h0f1571c947d9e8590cb7add6af7f6798, exp_pt: 128'h0};
    vecs[3] = '{c1: P, c2: {128'hffff, 128'h0123456789abcdef0011223344556677}, d: 256'h1234,
                ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, key: 128'h000102030405060708090a0b0c0d0e0f,
                exp_m: 128'h0123456789abcdef0011223344556677, exp_pt: 128'h00112233445566778899aabbccddeeff};
    vecs[4] = '{c1: P + 256'd3, c2: 256'h0, d: 256'd4,
                ct: 128'h3925841d02dc09fbdc118597196a0b32, key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                exp_m: 128'hC, exp_pt: 128'h3243f6a8885a308d313198a2e0370734};
    vecs[5] = '{c1: 256'd7, c2: 256'h1, d: 256'd3,
                ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, key: 128'h0,
                exp_m: 128'h14, exp_pt: 128'h0};
    vecs[6] = '{c1: 256'd2, c2: 256'h0, d: {1'b1, 255'b0},
                ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, key: 128'h000102030405060708090a0b0c0d0e0f,
                exp_m: 128'hFFFFFFFF000000000000000000000001, exp_pt: 128'h00112233445566778899aabbccddeeff};

    rst = 1'b0;
    C1 = '0; C2 = '0; d = '0; Cipher_test = '0; Aes_key = '0;
    #3;
    chk("reset_pt", plain_text, 128'h0);
    chk("reset_m", M_out, 128'h0);
    chk("reset_done", 128'(Done), 128'h0);

    for (int i = 0; i < 7; i++) begin
      start_run(vecs[i]);
      run_checks(vecs[i], $sformatf("v%0d", i));
    end

    // Reset asserted early in the ECC phase, then a complete fresh run.
    start_run(vecs[0]);
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst100_pt", plain_text, 128'h0);
    chk("midrst100_m", M_out, 128'h0);
    chk("midrst100_done", 128'(Done), 128'h0);
    @(negedge clk);
    rst = 1'b1;
    run_checks(vecs[0], "rerun100");

    // Reset asserted after M_out is already valid.
    start_run(vecs[1]);
    repeat (270) @(posedge clk);
    #1;
    chk("pre_rst270_m", M_out, vecs[1].exp_m);
    rst = 1'b0;
    #1;
    chk("midrst270_m", M_out, 128'h0);
    chk("midrst270_done", 128'(Done), 128'h0);
    C1 = vecs[1].c1; C2 = vecs[1].c2; d = vecs[1].d;
    Cipher_test = vecs[1].ct; Aes_key = vecs[1].key;
    @(negedge clk);
    rst = 1'b1;
    run_checks(vecs[1], "rerun270");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
